// File: rtl/uart_rx_cmd_decoder_pkg.sv
// Shared constants for the UART command decoder.
// Opcodes, state encoding, operand addresses and an opcode check.
package uart_rx_cmd_decoder_pkg;

  localparam logic [7:0] RF_WR_CMD   = 8'hAA;
  localparam logic [7:0] RF_RD_CMD   = 8'hBB;
  localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
  localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_ADDR = 3'd1;
  localparam state_t ST_WR_DATA = 3'd2;
  localparam state_t ST_RD_ADDR = 3'd3;
  localparam state_t ST_OPA     = 3'd4;
  localparam state_t ST_OPB     = 3'd5;
  localparam state_t ST_FUN     = 3'd6;

  function automatic logic is_cmd(logic [7:0] b);
    return b inside {RF_WR_CMD, RF_RD_CMD,
                     ALU_OP_CMD, ALU_NOP_CMD};
  endfunction

endpackage

// File: rtl/uart_rx_cmd_decoder_if.sv
// Byte-in / command-out bundle of the UART command decoder.
// master: byte source + system side; slave: the decoder.
interface uart_rx_cmd_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic                  RF_WR_EN;
  logic                  RF_RD_EN;
  logic [ADDR_WIDTH-1:0] RF_ADDR;
  logic [DATA_WIDTH-1:0] RF_WR_DATA;
  logic                  ALU_EN;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  logic                  CMD_ERR;
  logic                  DEC_BUSY;

  modport master (
    output RX_P_DATA, RX_D_VLD,
    input  RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA,
    input  ALU_EN, ALU_FUN, CMD_ERR, DEC_BUSY
  );

  modport slave (
    input  RX_P_DATA, RX_D_VLD,
    output RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA,
    output ALU_EN, ALU_FUN, CMD_ERR, DEC_BUSY
  );
endinterface

// File: rtl/uart_rx_cmd_timeout.sv
// Inter-byte idle counter; expire is high on the last idle cycle allowed.
// Ports: CLK, RST, clr (byte seen), en (frame open), expire.
module uart_rx_cmd_timeout #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt <= '0;
    else if (clr || !en)
      cnt <= '0;
    else if (cnt != MAX)
      cnt <= cnt + 1'b1;
  end

  // Fires when this idle cycle brings the count to TIMEOUT_CYC-1,
  // so the registered CMD_ERR lands TIMEOUT_CYC cycles after the byte.
  assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_cmd_decoder.sv
// Parses AA/BB/CC/DD command frames from the UART byte stream.
// Ports: CLK, RST, bus (slave: byte in, RF/ALU strobes and error out).
module uart_rx_cmd_decoder
  import uart_rx_cmd_decoder_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int FUN_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic CLK,
  input logic RST,
  uart_rx_cmd_decoder_if.slave bus
);
  state_t st_q, st_d;

  logic       vld;
  logic [7:0] op;
  logic       open_frame;
  logic       expire;

  logic wr_q, wr_d, rd_q, rd_d;
  logic alu_q, alu_d, err_q, err_d;
  logic busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [FUN_WIDTH-1:0]  fun_q, fun_d;

  assign vld        = bus.RX_D_VLD;
  assign op         = 8'(bus.RX_P_DATA);
  assign open_frame = (st_q != ST_IDLE);

  uart_rx_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (vld),
    .en    (open_frame),
    .expire(expire)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q   <= ST_IDLE;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      alu_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      addr_q <= '0;
      wdat_q <= '0;
      fun_q  <= '0;
    end else begin
      st_q   <= st_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      alu_q  <= alu_d;
      err_q  <= err_d;
      busy_q <= busy_d;
      addr_q <= addr_d;
      wdat_q <= wdat_d;
      fun_q  <= fun_d;
    end
  end

  // A byte on the expiry cycle takes priority over the abort.
  always_comb begin
    st_d = st_q;
    if (vld) begin
      unique case (st_q)
        ST_IDLE: begin
          unique case (1'b1)
            op == RF_WR_CMD:   st_d = ST_WR_ADDR;
            op == RF_RD_CMD:   st_d = ST_RD_ADDR;
            op == ALU_OP_CMD:  st_d = ST_OPA;
            op == ALU_NOP_CMD: st_d = ST_FUN;
            default:           st_d = ST_IDLE;
          endcase
        end
        ST_WR_ADDR: st_d = ST_WR_DATA;
        ST_OPA:     st_d = ST_OPB;
        ST_OPB:     st_d = ST_FUN;
        default:    st_d = ST_IDLE;
      endcase
    end else if (expire) begin
      st_d = ST_IDLE;
    end
  end

  always_comb begin
    wr_d   = 1'b0;
    rd_d   = 1'b0;
    alu_d  = 1'b0;
    err_d  = 1'b0;
    addr_d = addr_q;
    wdat_d = wdat_q;
    fun_d  = fun_q;
    if (vld) begin
      unique case (st_q)
        ST_IDLE:
          err_d = !is_cmd(op);
        ST_WR_ADDR:
          addr_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
        ST_WR_DATA: begin
          wdat_d = bus.RX_P_DATA;
          wr_d   = 1'b1;
        end
        ST_RD_ADDR: begin
          addr_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          rd_d   = 1'b1;
        end
        ST_OPA: begin
          addr_d = ADDR_WIDTH'(OPA_ADDR);
          wdat_d = bus.RX_P_DATA;
          wr_d   = 1'b1;
        end
        ST_OPB: begin
          addr_d = ADDR_WIDTH'(OPB_ADDR);
          wdat_d = bus.RX_P_DATA;
          wr_d   = 1'b1;
        end
        ST_FUN: begin
          fun_d = bus.RX_P_DATA[FUN_WIDTH-1:0];
          alu_d = 1'b1;
        end
        default: ;
      endcase
    end else if (expire) begin
      err_d = 1'b1;
    end
  end

  assign busy_d = (st_d != ST_IDLE);

  assign bus.RF_WR_EN   = wr_q;
  assign bus.RF_RD_EN   = rd_q;
  assign bus.RF_ADDR    = addr_q;
  assign bus.RF_WR_DATA = wdat_q;
  assign bus.ALU_EN     = alu_q;
  assign bus.ALU_FUN    = fun_q;
  assign bus.CMD_ERR    = err_q;
  assign bus.DEC_BUSY   = busy_q;

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Bench for uart_rx_cmd_decoder: directed frames plus random
// frames checked every cycle against a frame-level model.
module tb_uart_rx_cmd_decoder;
  localparam int TO = 32;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  uart_rx_cmd_decoder_if #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)
  ) bus ();

  uart_rx_cmd_decoder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4),
    .FUN_WIDTH(4), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level model: bytes of the open frame and idle run length.
  logic [7:0] fq[$];
  int         gap;
  logic       e_wr, e_rd, e_alu, e_err, e_busy;
  logic [3:0] e_addr, e_fun;
  logic [7:0] e_wdata;

  // Observed DUT activity for directed checks.
  int         n_wr, n_rd, n_alu, n_cerr;
  logic [3:0] last_waddr, last_raddr, last_fun;
  logic [7:0] last_wdata;
  time        t_vld, t_err;
  bit         err_seen;

  function automatic logic [31:0] exp_vec();
    return {11'd0, e_wr, e_rd, e_alu, e_err, e_busy,
            e_addr, e_wdata, e_fun};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {11'd0, bus.RF_WR_EN, bus.RF_RD_EN, bus.ALU_EN,
            bus.CMD_ERR, bus.DEC_BUSY, bus.RF_ADDR,
            bus.RF_WR_DATA, bus.ALU_FUN};
  endfunction

  task automatic model_reset();
    fq.delete();
    gap = 0;
    {e_wr, e_rd, e_alu, e_err, e_busy} = '0;
    e_addr = '0; e_fun = '0; e_wdata = '0;
  endtask

  task automatic model(bit v, logic [7:0] d);
    {e_wr, e_rd, e_alu, e_err} = '0;
    if (v) begin
      gap = 0;
      fq.push_back(d);
      if (fq.size() == 1) begin
        if (!(d inside {8'hAA, 8'hBB, 8'hCC, 8'hDD})) begin
          e_err = 1'b1;
          fq.delete();
        end
      end else begin
        case (fq[0])
          8'hAA: begin
            if (fq.size() == 2) e_addr = d[3:0];
            else begin
              e_wdata = d; e_wr = 1'b1; fq.delete();
            end
          end
          8'hBB: begin
            e_addr = d[3:0]; e_rd = 1'b1; fq.delete();
          end
          8'hCC: begin
            if (fq.size() == 4) begin
              e_fun = d[3:0]; e_alu = 1'b1; fq.delete();
            end else begin
              e_addr = (fq.size() == 2) ? 4'd0 : 4'd1;
              e_wdata = d; e_wr = 1'b1;
            end
          end
          default: begin
            e_fun = d[3:0]; e_alu = 1'b1; fq.delete();
          end
        endcase
      end
    end else if (fq.size() != 0) begin
      gap++;
      if (gap == TO - 1) begin
        e_err = 1'b1;
        fq.delete();
      end
    end
    e_busy = (fq.size() != 0);
  endtask

  task automatic step(bit v, logic [7:0] d);
    bus.RX_D_VLD  = v;
    bus.RX_P_DATA = d;
    if (v) t_vld = $time;
    @(posedge CLK);
    model(v, d);
    #1;
    chk("outs", dut_vec(), exp_vec());
    if (bus.RF_WR_EN) begin
      n_wr++;
      last_waddr = bus.RF_ADDR;
      last_wdata = bus.RF_WR_DATA;
    end
    if (bus.RF_RD_EN) begin
      n_rd++;
      last_raddr = bus.RF_ADDR;
    end
    if (bus.ALU_EN) begin
      n_alu++;
      last_fun = bus.ALU_FUN;
    end
    if (bus.CMD_ERR) begin
      n_cerr++;
      if (!err_seen) begin
        err_seen = 1'b1;
        t_err = $time;
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 8'($urandom));
  endtask

  task automatic send(logic [7:0] d, int g);
    step(1'b1, d);
    idle(g);
  endtask

  // Asserts reset between edges so the async clear is observed.
  task automatic do_reset();
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = '0;
    RST = 1'b1;
    #2;
    model_reset();
    chk("rst_async", dut_vec(), 32'd0);
    @(posedge CLK);
    #1;
    chk("rst_hold", dut_vec(), 32'd0);
    RST = 1'b0;
  endtask

  int b_wr, b_rd, b_alu, b_err;

  task automatic mark();
    b_wr = n_wr; b_rd = n_rd; b_alu = n_alu; b_err = n_cerr;
  endtask

  initial begin
    {n_wr, n_rd, n_alu, n_cerr} = '0;
    err_seen = 1'b0;
    t_vld = 0; t_err = 0;
    do_reset();

    mark();
    send(8'hAA, 19); send(8'h05, 19); send(8'h3C, 3);
    chk("t1_wr_cnt", n_wr - b_wr, 1);
    chk("t1_addr", last_waddr, 4'h5);
    chk("t1_data", last_wdata, 8'h3C);
    chk("t1_busy", bus.DEC_BUSY, 1'b0);

    mark();
    send(8'hBB, 1); send(8'h07, 3);
    chk("t2_rd_cnt", n_rd - b_rd, 1);
    chk("t2_addr", last_raddr, 4'h7);
    chk("t2_no_wr", n_wr - b_wr, 0);
    chk("t2_no_alu", n_alu - b_alu, 0);

    mark();
    send(8'hCC, 0); send(8'h12, 0); send(8'h34, 0);
    send(8'h02, 3);
    chk("t3_wr_cnt", n_wr - b_wr, 2);
    chk("t3_opb", {last_waddr, last_wdata}, 12'h134);
    chk("t3_alu", n_alu - b_alu, 1);
    chk("t3_fun", last_fun, 4'h2);

    mark();
    send(8'hDD, 2); send(8'hF3, 2);
    chk("t4_alu", n_alu - b_alu, 1);
    chk("t4_fun", last_fun, 4'h3);
    chk("t4_no_rf", (n_wr - b_wr) + (n_rd - b_rd), 0);
    send(8'h55, 2);
    chk("t4_err", n_cerr - b_err, 1);
    send(8'hBB, 1); send(8'h01, 2);
    chk("t4_rd", n_rd - b_rd, 1);
    chk("t4_raddr", last_raddr, 4'h1);

    mark();
    err_seen = 1'b0;
    send(8'hAA, TO + 5);
    chk("t5_err_seen", err_seen, 1'b1);
    chk("t5_lat", 32'((t_err - t_vld) / 10), TO);
    chk("t5_busy", bus.DEC_BUSY, 1'b0);
    send(8'hAA, 1); send(8'h01, 1); send(8'hFF, 2);
    chk("t5_wr", {last_waddr, last_wdata}, 12'h1FF);

    mark();
    send(8'hAA, TO - 2); send(8'h09, TO - 2); send(8'h77, 2);
    chk("t6_edge_wr", n_wr - b_wr, 1);
    chk("t6_edge_err", n_cerr - b_err, 0);
    chk("t6_edge_val", {last_waddr, last_wdata}, 12'h977);
    send(8'hCC, 1); send(8'h12, 1);
    do_reset();
    mark();
    send(8'hDD, 1); send(8'h04, 3);
    chk("t6_alu", n_alu - b_alu, 1);
    chk("t6_fun", last_fun, 4'h4);
    chk("t6_no_wr", n_wr - b_wr, 0);

    for (int f = 0; f < 300; f++) begin
      int r, nb;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      case (r)
        0, 1: begin b = 8'hAA; nb = 3; end
        2, 3: begin b = 8'hBB; nb = 2; end
        4, 5: begin b = 8'hCC; nb = 4; end
        6, 7: begin b = 8'hDD; nb = 2; end
        default: begin b = 8'($urandom); nb = 1; end
      endcase
      for (int k = 0; k < nb; k++) begin
        int g;
        if ($urandom_range(0, 15) == 0)
          g = $urandom_range(TO - 3, TO + 1);
        else
          g = $urandom_range(0, 3);
        send(b, g);
        b = 8'($urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
